mem_access_seq: RTL

- Upstream sequencer for the byte-wide main memory block.
- Owns the program counter and a memory address register.
- Accepts one fetch/read/write request at a time from the core over a valid/ready handshake.
- Drives the memory's address, direction, load and output-enable strobes, and returns read data (or write completion) on a response handshake.

---
 rtl/mem_seq_pkg.sv | 30 +++
 rtl/mem_access_seq_prog_counter.sv | 47 ++++
 rtl/mem_access_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_seq_pkg
//  Description : Shared encodings for the memory access sequencer: request
//                operation codes and sequencer state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_seq_pkg;

    // Default geometry of the byte-wide main memory path
    localparam int C_WIDTH      = 8;
    localparam int C_WIDTH_ADDR = 16;

    // Request operation codes presented by the core
    typedef enum logic [1:0] {
        OP_FETCH = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage : mem_seq_pkg
`default_nettype wire

// File: rtl/mem_access_seq_prog_counter.sv
`default_nettype none
// ============================================================================
//  Module      : prog_counter
//  Description : Program counter with parallel load, increment and natural
//                wrap from all-ones to zero. Load beats increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_counter #(
    parameter int                    WIDTH_ADDR = 16,
    parameter logic [WIDTH_ADDR-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH_ADDR-1:0] load_val,
    input  logic                  inc,
    output logic [WIDTH_ADDR-1:0] pc
);

    localparam logic [WIDTH_ADDR-1:0] C_ONE = {{(WIDTH_ADDR-1){1'b0}}, 1'b1};

    logic [WIDTH_ADDR-1:0] pc_q;
    logic [WIDTH_ADDR-1:0] pc_d;

    // Next PC: an explicit load overrides a fetch increment in the same cycle
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + C_ONE;
        end
    end

    // PC register, asynchronously returned to the reset vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule : prog_counter
`default_nettype wire

// File: rtl/mem_access_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_seq
//  Description : Upstream sequencer for the byte-wide main memory. Accepts
//                one fetch/read/write/nop request at a time, runs a single
//                ACCESS cycle against the memory, then holds the response
//                until the core consumes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_seq
    import mem_seq_pkg::*;
#(
    parameter int                    WIDTH      = 8,
    parameter int                    WIDTH_ADDR = 16,
    parameter logic [WIDTH_ADDR-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [WIDTH_ADDR-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    input  logic                  pc_load,
    input  logic [WIDTH_ADDR-1:0] pc_load_val,
    output logic [WIDTH_ADDR-1:0] pc,
    output logic [WIDTH_ADDR-1:0] mem_addr,
    output logic                  mem_bus_dir,
    output logic                  mem_load,
    output logic                  mem_assert_n,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata
);

    state_e                state_q,    state_d;
    op_e                   op_q,       op_d;
    logic [WIDTH_ADDR-1:0] addr_q,     addr_d;
    logic [WIDTH-1:0]      wdata_q,    wdata_d;
    logic [WIDTH-1:0]      rsp_data_q, rsp_data_d;

    logic                  w_req_ready;
    logic                  w_fetch_inc;
    logic [WIDTH_ADDR-1:0] w_pc;

    // A PC load in the same cycle blocks acceptance so a FETCH never latches a stale PC
    assign w_req_ready = (state_q == IDLE) && !pc_load;
    assign w_fetch_inc = (state_q == ACCESS) && (op_q == OP_FETCH);

    prog_counter #(
        .WIDTH_ADDR (WIDTH_ADDR),
        .RESET_PC   (RESET_PC)
    ) u_prog_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .load_val (pc_load_val),
        .inc      (w_fetch_inc),
        .pc       (w_pc)
    );

    // Next-state and datapath capture: latch request at accept, capture result at end of ACCESS
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (req_valid && w_req_ready) begin
                    state_d = ACCESS;
                    op_d    = op_e'(req_op);
                    addr_d  = (op_e'(req_op) == OP_FETCH) ? w_pc : req_addr;
                    wdata_d = req_data;
                end
            end
            ACCESS: begin
                state_d = RESP;
                case (op_q)
                    OP_FETCH, OP_READ: rsp_data_d = mem_rdata;
                    OP_WRITE:          rsp_data_d = wdata_q;
                    default:           rsp_data_d = '0;
                endcase
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_NOP;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Memory strobes decoded from registered state only, so request inputs can never glitch a write
    always_comb begin
        mem_bus_dir  = 1'b1;
        mem_load     = 1'b0;
        mem_assert_n = 1'b1;
        if (state_q == ACCESS) begin
            case (op_q)
                OP_FETCH, OP_READ: begin
                    mem_assert_n = 1'b0;
                end
                OP_WRITE: begin
                    mem_bus_dir = 1'b0;
                    mem_load    = 1'b1;
                end
                default: begin
                    mem_bus_dir  = 1'b1;
                end
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign pc        = w_pc;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule : mem_access_seq
`default_nettype wire
